// File: rtl/id_ex_stage_reg_if.sv
// ID -> EX stage bundle: decoder control, register data and fields in;
// registered EX-side copies, stall request and bubble counter out.
interface id_ex_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  // ID side
  logic              Branch_i;
  logic [1:0]        MemToReg_i;
  logic [1:0]        BranchType_i;
  logic              Jump_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [2:0]        ALUOp_i;
  logic              ALUSrc_i;
  logic              RegWrite_i;
  logic              RegDst_i;
  logic [DATA_W-1:0] pc_plus4_i;
  logic [DATA_W-1:0] rs_data_i;
  logic [DATA_W-1:0] rt_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [4:0]        rs_i;
  logic [4:0]        rt_i;
  logic [4:0]        rd_i;
  logic              flush_i;
  logic              hold_i;

  // EX side
  logic              stall_o;
  logic              valid_o;
  logic              Branch_o;
  logic [1:0]        MemToReg_o;
  logic [1:0]        BranchType_o;
  logic              Jump_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic [2:0]        ALUOp_o;
  logic              ALUSrc_o;
  logic              RegWrite_o;
  logic              RegDst_o;
  logic [DATA_W-1:0] pc_plus4_o;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [4:0]        rs_o;
  logic [4:0]        rt_o;
  logic [4:0]        rd_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output Branch_i, MemToReg_i, BranchType_i, Jump_i, MemRead_i, MemWrite_i,
           ALUOp_i, ALUSrc_i, RegWrite_i, RegDst_i,
           pc_plus4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
           flush_i, hold_i,
    input  stall_o, valid_o,
           Branch_o, MemToReg_o, BranchType_o, Jump_o, MemRead_o, MemWrite_o,
           ALUOp_o, ALUSrc_o, RegWrite_o, RegDst_o,
           pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
           bubble_cnt_o
  );

  modport slave (
    input  Branch_i, MemToReg_i, BranchType_i, Jump_i, MemRead_i, MemWrite_i,
           ALUOp_i, ALUSrc_i, RegWrite_i, RegDst_i,
           pc_plus4_i, rs_data_i, rt_data_i, imm_i, rs_i, rt_i, rd_i,
           flush_i, hold_i,
    output stall_o, valid_o,
           Branch_o, MemToReg_o, BranchType_o, Jump_o, MemRead_o, MemWrite_o,
           ALUOp_o, ALUSrc_o, RegWrite_o, RegDst_o,
           pc_plus4_o, rs_data_o, rt_data_o, imm_o, rs_o, rt_o, rd_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold
// handling and a saturating count of load-use bubbles.
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_reg_if.slave stage
);

  typedef struct packed {
    logic       branch;
    logic [1:0] memToReg;
    logic [1:0] branchType;
    logic       jump;
    logic       memRead;
    logic       memWrite;
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       regDst;
  } ctrl_t;

  // Jump is active-low from the decoder, so a bubble carries jump=1.
  localparam ctrl_t CTRL_BUBBLE = '{jump: 1'b1, default: '0};

  ctrl_t             ctrlIn;
  ctrl_t             ctrlReg;
  logic              validReg;
  logic [DATA_W-1:0] pcPlus4Reg;
  logic [DATA_W-1:0] rsDataReg;
  logic [DATA_W-1:0] rtDataReg;
  logic [DATA_W-1:0] immReg;
  logic [4:0]        rsReg;
  logic [4:0]        rtReg;
  logic [4:0]        rdReg;
  logic [CNT_W-1:0]  bubbleCntReg;

  logic hazard;
  logic advance;
  logic insertBubble;
  logic countBubble;

  assign ctrlIn = '{
    branch:     stage.Branch_i,
    memToReg:   stage.MemToReg_i,
    branchType: stage.BranchType_i,
    jump:       stage.Jump_i,
    memRead:    stage.MemRead_i,
    memWrite:   stage.MemWrite_i,
    aluOp:      stage.ALUOp_i,
    aluSrc:     stage.ALUSrc_i,
    regWrite:   stage.RegWrite_i,
    regDst:     stage.RegDst_i
  };

  // A load in EX whose destination feeds either ID source; $zero never hazards.
  assign hazard = ctrlReg.memRead & validReg & (rtReg != 5'd0)
                & ((rtReg == stage.rs_i) | (rtReg == stage.rt_i));

  assign stage.stall_o = hazard & ~stage.flush_i & ~stage.hold_i;

  // Flush overrides hold; otherwise hold freezes everything.
  assign advance      = stage.flush_i | ~stage.hold_i;
  assign insertBubble = stage.flush_i | hazard;
  assign countBubble  = stage.stall_o & (bubbleCntReg != {CNT_W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrlReg      <= '0;
      validReg     <= 1'b0;
      pcPlus4Reg   <= '0;
      rsDataReg    <= '0;
      rtDataReg    <= '0;
      immReg       <= '0;
      rsReg        <= '0;
      rtReg        <= '0;
      rdReg        <= '0;
      bubbleCntReg <= '0;
    end else begin
      if (advance) begin
        pcPlus4Reg <= stage.pc_plus4_i;
        rsDataReg  <= stage.rs_data_i;
        rtDataReg  <= stage.rt_data_i;
        immReg     <= stage.imm_i;
        rsReg      <= stage.rs_i;
        rtReg      <= stage.rt_i;
        rdReg      <= stage.rd_i;
        if (insertBubble) begin
          ctrlReg  <= CTRL_BUBBLE;
          validReg <= 1'b0;
        end else begin
          ctrlReg  <= ctrlIn;
          validReg <= 1'b1;
        end
      end
      if (countBubble) begin
        bubbleCntReg <= bubbleCntReg + 1'b1;
      end
    end
  end

  assign stage.valid_o      = validReg;
  assign stage.Branch_o     = ctrlReg.branch;
  assign stage.MemToReg_o   = ctrlReg.memToReg;
  assign stage.BranchType_o = ctrlReg.branchType;
  assign stage.Jump_o       = ctrlReg.jump;
  assign stage.MemRead_o    = ctrlReg.memRead;
  assign stage.MemWrite_o   = ctrlReg.memWrite;
  assign stage.ALUOp_o      = ctrlReg.aluOp;
  assign stage.ALUSrc_o     = ctrlReg.aluSrc;
  assign stage.RegWrite_o   = ctrlReg.regWrite;
  assign stage.RegDst_o     = ctrlReg.regDst;
  assign stage.pc_plus4_o   = pcPlus4Reg;
  assign stage.rs_data_o    = rsDataReg;
  assign stage.rt_data_o    = rtDataReg;
  assign stage.imm_o        = immReg;
  assign stage.rs_o         = rsReg;
  assign stage.rt_o         = rtReg;
  assign stage.rd_o         = rdReg;
  assign stage.bubble_cnt_o = bubbleCntReg;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg; the bubble counter is narrowed so
// saturation is reachable in a short run.
module tb_id_ex_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;

  logic clk;
  logic rstN;
  int   testCount;
  int   failCount;

  id_ex_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .stage (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    if (obs !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    bus.Branch_i     = 1'b0;
    bus.MemToReg_i   = 2'b00;
    bus.BranchType_i = 2'b00;
    bus.Jump_i       = 1'b1;
    bus.MemRead_i    = 1'b0;
    bus.MemWrite_i   = 1'b0;
    bus.ALUOp_i      = 3'b000;
    bus.ALUSrc_i     = 1'b0;
    bus.RegWrite_i   = 1'b0;
    bus.RegDst_i     = 1'b0;
    bus.pc_plus4_i   = '0;
    bus.rs_data_i    = '0;
    bus.rt_data_i    = '0;
    bus.imm_i        = '0;
    bus.rs_i         = 5'd0;
    bus.rt_i         = 5'd0;
    bus.rd_i         = 5'd0;
    bus.flush_i      = 1'b0;
    bus.hold_i       = 1'b0;
  endtask

  task automatic randomIn();
    bus.Branch_i     = 1'($urandom);
    bus.MemToReg_i   = 2'($urandom);
    bus.BranchType_i = 2'($urandom);
    bus.Jump_i       = 1'($urandom);
    bus.MemRead_i    = 1'($urandom);
    bus.MemWrite_i   = 1'($urandom);
    bus.ALUOp_i      = 3'($urandom);
    bus.ALUSrc_i     = 1'($urandom);
    bus.RegWrite_i   = 1'($urandom);
    bus.RegDst_i     = 1'($urandom);
    bus.pc_plus4_i   = $urandom;
    bus.rs_data_i    = $urandom;
    bus.rt_data_i    = $urandom;
    bus.imm_i        = $urandom;
    bus.rs_i         = 5'($urandom);
    bus.rt_i         = 5'($urandom);
    bus.rd_i         = 5'($urandom);
    bus.flush_i      = 1'($urandom);
    bus.hold_i       = 1'($urandom);
  endtask

  task automatic loadWord(input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] pc);
    clearIn();
    bus.MemRead_i  = 1'b1;
    bus.MemToReg_i = 2'b01;
    bus.ALUSrc_i   = 1'b1;
    bus.RegWrite_i = 1'b1;
    bus.rs_i       = rs;
    bus.rt_i       = rt;
    bus.pc_plus4_i = pc;
  endtask

  task automatic rType(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] pc);
    clearIn();
    bus.RegWrite_i = 1'b1;
    bus.RegDst_i   = 1'b1;
    bus.ALUOp_i    = 3'b010;
    bus.rs_i       = rs;
    bus.rt_i       = rt;
    bus.rd_i       = rd;
    bus.pc_plus4_i = pc;
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rstN = 1'b0;
    clearIn();

    // Reset with random inputs
    repeat (3) begin
      randomIn();
      tick();
    end
    checkVal("rst_valid",    64'(bus.valid_o),      64'd0);
    checkVal("rst_regwrite", 64'(bus.RegWrite_o),   64'd0);
    checkVal("rst_jump",     64'(bus.Jump_o),       64'd0);
    checkVal("rst_aluop",    64'(bus.ALUOp_o),      64'd0);
    checkVal("rst_pc",       64'(bus.pc_plus4_o),   64'd0);
    checkVal("rst_rtdata",   64'(bus.rt_data_o),    64'd0);
    checkVal("rst_rd",       64'(bus.rd_o),         64'd0);
    checkVal("rst_cnt",      64'(bus.bubble_cnt_o), 64'd0);
    checkVal("rst_stall",    64'(bus.stall_o),      64'd0);

    // First R-type after reset
    rstN = 1'b1;
    rType(5'd1, 5'd2, 5'd3, 32'h0000_0104);
    bus.rs_data_i = 32'h1111_1111;
    bus.rt_data_i = 32'h2222_2222;
    bus.imm_i     = 32'h0000_1234;
    tick();
    checkVal("r_valid",    64'(bus.valid_o),    64'd1);
    checkVal("r_regwrite", 64'(bus.RegWrite_o), 64'd1);
    checkVal("r_regdst",   64'(bus.RegDst_o),   64'd1);
    checkVal("r_aluop",    64'(bus.ALUOp_o),    64'd2);
    checkVal("r_jump",     64'(bus.Jump_o),     64'd1);
    checkVal("r_pc",       64'(bus.pc_plus4_o), 64'h104);
    checkVal("r_rsdata",   64'(bus.rs_data_o),  64'h1111_1111);
    checkVal("r_rtdata",   64'(bus.rt_data_o),  64'h2222_2222);
    checkVal("r_imm",      64'(bus.imm_o),      64'h1234);
    checkVal("r_fields",   64'({bus.rs_o, bus.rt_o, bus.rd_o}), 64'({5'd1, 5'd2, 5'd3}));
    checkVal("r_stall",    64'(bus.stall_o),    64'd0);

    // Load-use: lw rt=5 then add rs=5
    loadWord(5'd4, 5'd5, 32'h0000_0108);
    tick();
    checkVal("lw_memread", 64'(bus.MemRead_o),  64'd1);
    checkVal("lw_memtoreg", 64'(bus.MemToReg_o), 64'd1);
    rType(5'd5, 5'd6, 5'd7, 32'h0000_010C);
    #1;
    checkVal("lu_stall", 64'(bus.stall_o), 64'd1);
    tick();
    checkVal("lu_bub_regwrite", 64'(bus.RegWrite_o),   64'd0);
    checkVal("lu_bub_memread",  64'(bus.MemRead_o),    64'd0);
    checkVal("lu_bub_jump",     64'(bus.Jump_o),       64'd1);
    checkVal("lu_bub_valid",    64'(bus.valid_o),      64'd0);
    checkVal("lu_bub_cnt",      64'(bus.bubble_cnt_o), 64'd1);
    checkVal("lu_bub_stall",    64'(bus.stall_o),      64'd0);
    tick();
    checkVal("lu_add_valid",    64'(bus.valid_o),    64'd1);
    checkVal("lu_add_rs",       64'(bus.rs_o),       64'd5);
    checkVal("lu_add_regwrite", 64'(bus.RegWrite_o), 64'd1);
    checkVal("lu_add_pc",       64'(bus.pc_plus4_o), 64'h10C);
    checkVal("lu_add_stall",    64'(bus.stall_o),    64'd0);

    // No false stall: destination $zero, and unrelated sources
    loadWord(5'd3, 5'd0, 32'h0000_0110);
    tick();
    rType(5'd0, 5'd0, 5'd1, 32'h0000_0114);
    #1;
    checkVal("rt0_stall", 64'(bus.stall_o), 64'd0);
    loadWord(5'd1, 5'd5, 32'h0000_0118);
    tick();
    rType(5'd6, 5'd7, 5'd1, 32'h0000_011C);
    #1;
    checkVal("nodep_stall", 64'(bus.stall_o), 64'd0);
    bus.rs_i = 5'd9;
    bus.rt_i = 5'd5;
    #1;
    checkVal("rtdep_stall", 64'(bus.stall_o), 64'd1);

    // Flush wins over the hazard and is not counted
    bus.flush_i = 1'b1;
    #1;
    checkVal("fl_stall", 64'(bus.stall_o), 64'd0);
    tick();
    checkVal("fl_valid",   64'(bus.valid_o),      64'd0);
    checkVal("fl_jump",    64'(bus.Jump_o),       64'd1);
    checkVal("fl_memread", 64'(bus.MemRead_o),    64'd0);
    checkVal("fl_cnt",     64'(bus.bubble_cnt_o), 64'd1);

    // Hold freezes a load in EX even with a dependent ID instruction
    loadWord(5'd1, 5'd7, 32'h0000_0200);
    tick();
    for (int i = 0; i < 3; i++) begin
      rType(5'd7, 5'd2, 5'd3, 32'h0000_0210 + 32'(i * 4));
      bus.rs_data_i = $urandom;
      bus.hold_i    = 1'b1;
      #1;
      checkVal("hold_stall", 64'(bus.stall_o), 64'd0);
      tick();
      checkVal("hold_pc",      64'(bus.pc_plus4_o), 64'h200);
      checkVal("hold_memread", 64'(bus.MemRead_o),  64'd1);
      checkVal("hold_valid",   64'(bus.valid_o),    64'd1);
      checkVal("hold_rt",      64'(bus.rt_o),       64'd7);
    end
    checkVal("hold_cnt", 64'(bus.bubble_cnt_o), 64'd1);
    rType(5'd8, 5'd9, 5'd10, 32'h0000_0300);
    #1;
    checkVal("rel_stall", 64'(bus.stall_o), 64'd0);
    tick();
    checkVal("rel_pc",       64'(bus.pc_plus4_o), 64'h300);
    checkVal("rel_memread",  64'(bus.MemRead_o),  64'd0);
    checkVal("rel_regwrite", 64'(bus.RegWrite_o), 64'd1);
    checkVal("rel_valid",    64'(bus.valid_o),    64'd1);

    // Saturation: lw rs=5 rt=5 repeated gives one bubble every two cycles
    loadWord(5'd5, 5'd5, 32'h0000_0400);
    for (int k = 1; k <= 260; k++) begin
      tick();
      if (k == 1) checkVal("sat_stall", 64'(bus.stall_o), 64'd1);
      tick();
      if (k == 253) checkVal("sat_cnt_254", 64'(bus.bubble_cnt_o), 64'hFE);
      if (k == 254) checkVal("sat_cnt_255", 64'(bus.bubble_cnt_o), 64'hFF);
    end
    checkVal("sat_nowrap", 64'(bus.bubble_cnt_o), 64'hFF);

    // Asynchronous reset in the middle of a stall
    tick();
    checkVal("mid_stall_pre", 64'(bus.stall_o), 64'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkVal("mid_stall",   64'(bus.stall_o),      64'd0);
    checkVal("mid_valid",   64'(bus.valid_o),      64'd0);
    checkVal("mid_cnt",     64'(bus.bubble_cnt_o), 64'd0);
    checkVal("mid_memread", 64'(bus.MemRead_o),    64'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
